box_map: RTL

Tile-occupancy store and address generator for the destructible boxes in the 640x480 arena. It holds one presence bit per 32x32 tile, which gives a 20x15 grid. From the VGA pixel coordinates it drives the row/col address of the box sprite ROM and raises `box_on` so that it lines up with that ROM's one-cycle-late `color_data`. It also services explosion destroy requests over a four-phase handshake, answers collision queries from player logic, and tracks how many boxes remain.

---
 rtl/box_map_pkg.sv | 31 +++
 rtl/box_map_tile_index.sv | 16 +
 rtl/box_map.sv | 93 +++++++++
 3 files changed

// File: rtl/box_map_pkg.sv
// Shared constants for the box tile store: arena grid geometry, the initial
// box layout and the destroy handshake state encoding.
package box_map_pkg;

   localparam int GRID_COLS   = 20;
   localparam int GRID_ROWS   = 15;
   localparam int TILE_BITS   = 5;
   localparam int BITMAP_BITS = GRID_COLS * GRID_ROWS;

   // One 20-bit word per tile row, row 0 in the least significant bits.
   localparam logic [BITMAP_BITS-1:0] BOX_INIT = {
      20'h00000, 20'h0A5A0, 20'h55558, 20'h00A00, 20'h4AA52,
      20'h10001, 20'h2A954, 20'h00000, 20'h2A954, 20'h10001,
      20'h4AA52, 20'h00A00, 20'h55558, 20'h0A5A0, 20'h00000
   };

   function automatic int count_ones(input logic [BITMAP_BITS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < BITMAP_BITS; i++) n += int'(v[i]);
      return n;
   endfunction

   localparam int BOX_INIT_COUNT = count_ones(BOX_INIT);

   typedef enum logic {
      DST_IDLE,
      DST_ACK
   } dst_state_t;

endpackage

// File: rtl/box_map_tile_index.sv
// Maps a (tile row, tile column) pair to its bitmap bit index and flags
// whether the tile lies inside the 20x15 arena.
module tile_index
   import box_map_pkg::*;
(
   input  logic [4:0] row,
   input  logic [4:0] col,
   output logic [8:0] idx,
   output logic       in_range
);

   assign in_range = (row < 5'(GRID_ROWS)) && (col < 5'(GRID_COLS));
   // Only the low four row bits matter once in_range gates the result.
   assign idx = 9'(row[3:0]) * 9'(GRID_COLS) + 9'(col);

endmodule

// File: rtl/box_map.sv
// Box occupancy bitmap with video address generation, a four-phase destroy
// handshake, registered collision queries and a live-box counter.
module box_map
   import box_map_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       video_on,
   output logic [4:0] rom_row,
   output logic [4:0] rom_col,
   output logic       box_on,
   input  logic       destroy_req,
   input  logic [3:0] destroy_tr,
   input  logic [4:0] destroy_tc,
   output logic       destroy_ack,
   output logic       destroy_hit,
   input  logic [3:0] query_tr,
   input  logic [4:0] query_tc,
   output logic       query_box,
   input  logic       reload,
   output logic [8:0] boxes_left,
   output logic       all_clear
);

   logic [BITMAP_BITS-1:0] bitmap;
   logic [8:0]             count_q;
   dst_state_t             state, state_next;
   logic                   fire;
   logic                   hit_q;

   logic [8:0] vid_idx, dst_idx, qry_idx;
   logic       vid_in, dst_in, qry_in;
   logic       dst_present;

   tile_index u_vid_idx (.row(y[9:5]),            .col(x[9:5]),     .idx(vid_idx), .in_range(vid_in));
   tile_index u_dst_idx (.row({1'b0, destroy_tr}), .col(destroy_tc), .idx(dst_idx), .in_range(dst_in));
   tile_index u_qry_idx (.row({1'b0, query_tr}),   .col(query_tc),   .idx(qry_idx), .in_range(qry_in));

   assign rom_row     = y[TILE_BITS-1:0];
   assign rom_col     = x[TILE_BITS-1:0];
   assign dst_present = dst_in && bitmap[dst_idx];

   // NOTE: every output of a combinational block is given a default first,
   // so no path through the case statement can infer a latch.
   always_comb begin
      state_next = state;
      fire       = 1'b0;
      case (state)
         DST_IDLE: if (destroy_req) begin
            fire       = 1'b1;
            state_next = DST_ACK;
         end
         DST_ACK:  if (!destroy_req) state_next = DST_IDLE;
         default:  state_next = DST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every read below sees the
   // pre-edge bitmap, which is what gives queries their "before destroy" view.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the bitmap is ordinary flops, so it is reset to the layout
         // directly rather than being cleared by a separate init sequence.
         bitmap    <= BOX_INIT;
         count_q   <= 9'(BOX_INIT_COUNT);
         state     <= DST_IDLE;
         hit_q     <= 1'b0;
         box_on    <= 1'b0;
         query_box <= 1'b0;
      end else begin
         state     <= state_next;
         box_on    <= video_on && vid_in && bitmap[vid_idx];
         query_box <= qry_in && bitmap[qry_idx];
         if (fire) hit_q <= dst_present && !reload;
         // Reload wins over a destroy sampled in the same cycle.
         if (reload) begin
            bitmap  <= BOX_INIT;
            count_q <= 9'(BOX_INIT_COUNT);
         end else if (fire && dst_present) begin
            bitmap[dst_idx] <= 1'b0;
            count_q         <= count_q - 9'd1;
         end
      end
   end

   assign destroy_ack = (state == DST_ACK);
   assign destroy_hit = destroy_ack && hit_q;
   assign boxes_left  = count_q;
   assign all_clear   = (count_q == 9'd0);

endmodule
